// File: rtl/motor_pkg.sv
// Shared command encodings, sequencer state type and command classification
// for the IR-driven motor command sequencer.
package motor_pkg;

  localparam logic [7:0] CMD_BRAKE = 8'h10;
  localparam logic [7:0] CMD_FWD   = 8'h02;
  localparam logic [7:0] CMD_LEFT  = 8'h08;
  localparam logic [7:0] CMD_RIGHT = 8'h20;
  localparam logic [7:0] CMD_BACK  = 8'h80;

  typedef enum logic [1:0] {
    BRAKE,
    DEAD,
    RAMP,
    RUN
  } seq_state_t;

  function automatic logic is_motion_cmd(input logic [7:0] code);
    return (code == CMD_FWD) || (code == CMD_LEFT) ||
           (code == CMD_RIGHT) || (code == CMD_BACK);
  endfunction

endpackage

// File: rtl/motor_timer.sv
// Reloadable down-counter. 'expired' flags the last counted cycle of a load,
// so a load of N gives N enabled cycles with expiry on the Nth.
module motor_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: defaults first so every path assigns count_d; no latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: blocking in always_comb, non-blocking for registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q <= WIDTH'(1));

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Validates IR command bytes and sequences brake / dead-time / soft-start ramp.
// Define MOTOR_SEQ_WATCHDOG_EN to build the command-loss watchdog.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_CYC      = 2_500_000,
  parameter int unsigned RAMP_STEP_CYC = 500_000,
  parameter logic [4:0]  DUTY_MIN      = 5'd4,
  parameter logic [4:0]  DUTY_MAX      = 5'd20,
  parameter int unsigned TIMEOUT_CYC   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir_code,
  input  logic       ir_valid,
  output logic [7:0] motion_cmd,
  output logic [4:0] duty,
  output logic       settled
);

  localparam int unsigned DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int unsigned RAMP_W = $clog2(RAMP_STEP_CYC + 1);

  seq_state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] pending_q, pending_d;
  logic [4:0] duty_q, duty_d;
  logic       settled_q;

  logic is_motion, is_brake, rec_valid;
  logic dead_load, dead_expired;
  logic ramp_load, ramp_expired;
  logic wd_expired;

  assign is_motion = ir_valid && is_motion_cmd(ir_code);
  assign is_brake  = ir_valid && (ir_code == CMD_BRAKE);
  assign rec_valid = is_motion || is_brake;

  motor_timer #(.WIDTH(DEAD_W)) u_dead_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dead_load),
    .load_val (DEAD_W'(DEAD_CYC)),
    .en       (state_q == DEAD),
    .expired  (dead_expired)
  );

  motor_timer #(.WIDTH(RAMP_W)) u_ramp_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ramp_load),
    .load_val (RAMP_W'(RAMP_STEP_CYC)),
    .en       (state_q == RAMP),
    .expired  (ramp_expired)
  );

`ifdef MOTOR_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  // Held loaded while braked, so the count always starts fresh on leaving BRAKE.
  motor_timer #(.WIDTH(WD_W)) u_wd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rec_valid || (state_q == BRAKE)),
    .load_val (WD_W'(TIMEOUT_CYC)),
    .en       (state_q != BRAKE),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    duty_d    = duty_q;
    pending_d = pending_q;
    dead_load = 1'b0;
    ramp_load = 1'b0;

    unique case (state_q)
      BRAKE: begin
        if (is_motion) begin
          cmd_d     = ir_code;
          duty_d    = DUTY_MIN;
          ramp_load = 1'b1;
          state_d   = (DUTY_MIN >= DUTY_MAX) ? RUN : RAMP;
        end
      end

      DEAD: begin
        if (is_motion) pending_d = ir_code;
        if (is_brake || (wd_expired && !rec_valid)) begin
          state_d   = BRAKE;
          pending_d = '0;
        end else if (dead_expired) begin
          cmd_d     = pending_d;
          duty_d    = DUTY_MIN;
          ramp_load = 1'b1;
          state_d   = (DUTY_MIN >= DUTY_MAX) ? RUN : RAMP;
        end
      end

      RAMP, RUN: begin
        if (is_brake || (wd_expired && !rec_valid)) begin
          state_d   = BRAKE;
          cmd_d     = CMD_BRAKE;
          duty_d    = '0;
          pending_d = '0;
        end else if (is_motion && (ir_code != cmd_q)) begin
          pending_d = ir_code;
          cmd_d     = CMD_BRAKE;
          duty_d    = '0;
          dead_load = 1'b1;
          state_d   = DEAD;
        end else if ((state_q == RAMP) && ramp_expired) begin
          duty_d    = (duty_q >= DUTY_MAX) ? DUTY_MAX : duty_q + 5'd1;
          ramp_load = 1'b1;
          if (duty_d == DUTY_MAX) state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BRAKE;
      cmd_q     <= CMD_BRAKE;
      duty_q    <= '0;
      pending_q <= '0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      duty_q    <= duty_d;
      pending_q <= pending_d;
      settled_q <= (state_d == RUN);
    end
  end

  assign motion_cmd = cmd_q;
  assign duty       = duty_q;
  assign settled    = settled_q;

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Sits between the IR command decoder and the dual-motor driver block. Validates one-hot IR command bytes and forwards a safe direction command plus a 5-bit PWM duty to the driver. Enforces a braked dead-time on every direction change and a soft-start duty ramp. A watchdog brakes the robot if commands stop arriving.

Parameters:
DEAD_CYC, 2_500_000, cycles held in brake between two different motion commands (50 ms at 50 MHz)
RAMP_STEP_CYC, 500_000, cycles per +1 duty step during soft-start
DUTY_MIN, 5'd4, first duty value applied when motion starts
DUTY_MAX, 5'd20, steady-state duty; must satisfy DUTY_MIN <= DUTY_MAX
TIMEOUT_CYC, 25_000_000, cycles without a recognised command before forced brake

Ports:
clk  in  1  system clock, 50 MHz; single clock domain
rst  in  1  synchronous reset, active-high
ir_code  in  8  command byte from the IR decoder
ir_valid  in  1  one-cycle strobe; ir_code is sampled when high
motion_cmd  out  8  one-hot command to the driver: 0x10 brake, 0x02 fwd, 0x08 left, 0x20 right, 0x80 back
duty  out  5  PWM duty to the driver
settled  out  1  high only in RUN (duty == DUTY_MAX, no transition pending)

Behaviour:
- Reset (sync, any state): state BRAKE, motion_cmd=0x10, duty=0, settled=0, all timers cleared, pending cleared.
- Recognised codes are exactly 0x10, 0x02, 0x08, 0x20, 0x80. Any other byte with ir_valid is ignored completely and does not refresh the watchdog.
- All outputs are registered. A command accepted in cycle N takes effect on the outputs in cycle N+1.
- States: BRAKE, DEAD, RAMP, RUN.
- BRAKE: outputs 0x10 / 0. On a motion code: go to RAMP with motion_cmd=code and duty=DUTY_MIN. On brake code: stay.
- RAMP: the step timer counts RAMP_STEP_CYC cycles, then duty increments by 1. When duty == DUTY_MAX, go to RUN; this includes the first cycle if DUTY_MIN == DUTY_MAX.
- RUN: duty=DUTY_MAX, settled=1.
- In RAMP or RUN:
  - Same motion code: refresh the watchdog only; ramp progress is unaffected.
  - Brake code: go to BRAKE immediately.
  - Different motion code: store it in pending, set outputs to 0x10 / 0, load DEAD_CYC, go to DEAD.
- DEAD: outputs 0x10 / 0.
  - New motion code: overwrites pending; the dead timer is NOT restarted.
  - Brake code: abort to BRAKE and clear pending.
  - Timer expiry: go to RAMP with motion_cmd=pending and duty=DUTY_MIN.
- Watchdog:
  - Counter clears on every recognised ir_valid and on entry to BRAKE.
  - Reaching TIMEOUT_CYC in DEAD, RAMP or RUN forces BRAKE.
  - If a recognised ir_valid arrives in the same cycle as expiry, the command wins and the watchdog is refreshed.
- Counter widths are $clog2(param+1). Duty arithmetic is 5-bit, saturating at DUTY_MAX, and never wraps.
- Reset asserted mid-ramp or mid-dead-time returns to the reset state on the next edge; pending is discarded.

Optional Feature:
MOTOR_SEQ_WATCHDOG_EN
- Defined: watchdog behaves as specified above.
- Undefined: no watchdog counter is synthesised and the last command persists indefinitely. All other behaviour is identical.

Decomposition:
- Package motor_pkg holds:
  - localparams CMD_BRAKE=8'h10, CMD_FWD=8'h02, CMD_LEFT=8'h08, CMD_RIGHT=8'h20, CMD_BACK=8'h80
  - typedef enum logic [1:0] seq_state_t {BRAKE, DEAD, RAMP, RUN}
  - function is_motion_cmd(byte) returning 1 for the four motion codes
- One sub-module, motor_timer: a reloadable down-counter.
  - Ports: clk, rst, load, load_val, en; outputs expired.
  - Instantiated for dead-time, ramp step and watchdog.

Test Plan:
(Bench parameters: DEAD_CYC=4, RAMP_STEP_CYC=2, DUTY_MIN=4, DUTY_MAX=8, TIMEOUT_CYC=40.)
- Reset, then ir 0x02 -> next cycle motion_cmd=0x02, duty=4; duty reaches 8 after 4 steps of 2 cycles; settled=1 from that point.
- In RUN, ir 0x80 -> motion_cmd=0x10, duty=0 for 4 cycles, then 0x80 with duty=4, ramping again.
- In DEAD, ir 0x08 at dead cycle 2 -> dead-time still ends at cycle 4, then 0x08 ramps; a brake code sent instead -> BRAKE and no ramp follows.
- ir 0x33 and 0x00 strobes while in RUN -> outputs unchanged and watchdog not refreshed.
- With MOTOR_SEQ_WATCHDOG_EN: no command for 40 cycles in RUN -> 0x10 / 0. A 0x02 arriving on the expiry cycle -> stays RUN. With the macro undefined, the robot is still in RUN after 1000 idle cycles.
- Assert rst mid-RAMP (duty=6) -> next edge gives 0x10 / 0 / settled=0; ir 0x20 afterwards starts a fresh ramp from 4.
